// File: rtl/barcode_prefix_matcher.sv
// -----------------------------------------------------------------------------
// barcode_prefix_matcher
//   Barcode entry and product-highlight engine for the sale terminal. Keypad
//   digits are collected one at a time. The first digit goes into the most
//   significant slot. After every accepted event the engine registers:
//     - the per-product prefix-match mask,
//     - the match statistics.
//   Backspace removes the last digit and clear discards the whole entry.
//   Priority within one cycle is clear > backspace > digit.
//
//   Optional feature macro: BARCODE_AUTOCOMPLETE_EN
//     When it is defined, an accepted digit that leaves exactly one candidate
//     product loads that product's full barcode and completes the entry.
//
// Ports
//   clk              rising-edge system clock
//   rst_n            asynchronous active-low reset
//   digit_valid_i    digit strobe, one cycle per keypress
//   digit_in_i       digit value, sampled with digit_valid_i
//   backspace_i      remove last digit (pulse)
//   clear_i          discard entry (pulse)
//   highlight_en_i   0 blanks highlight_mask_o (display gating only)
//   barcode_o        entered digits, unentered slots are 0
//   digit_count_o    digits currently entered
//   highlight_mask_o bit i set when product i matches the prefix (gated)
//   match_count_o    popcount of the ungated match mask
//   unique_match_o   exactly one match and at least one digit entered
//   match_index_o    lowest matching product index, 0 when none
//   entry_done_o     entry is complete
//   done_pulse_o     one cycle on entry into COMPLETE
//   err_pulse_o      one cycle when a request is rejected
// -----------------------------------------------------------------------------
module barcode_prefix_matcher #(
  parameter int NUM_PRODUCTS = 12,
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_W      = 4,
  parameter int DIGIT_MAX    = 4,
  parameter logic [NUM_PRODUCTS*NUM_DIGITS*DIGIT_W-1:0] PRODUCT_TABLE = {
    16'h1213, 16'h1342, 16'h4321, 16'h3112, 16'h2144, 16'h2134, 16'h3214, 16'h3133,
    16'h3121, 16'h4133, 16'h4132, 16'h3124}
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                digit_valid_i,
  input  logic [DIGIT_W-1:0]                  digit_in_i,
  input  logic                                backspace_i,
  input  logic                                clear_i,
  input  logic                                highlight_en_i,
  output logic [NUM_DIGITS*DIGIT_W-1:0]       barcode_o,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     digit_count_o,
  output logic [NUM_PRODUCTS-1:0]             highlight_mask_o,
  output logic [$clog2(NUM_PRODUCTS+1)-1:0]   match_count_o,
  output logic                                unique_match_o,
  output logic [$clog2(NUM_PRODUCTS)-1:0]     match_index_o,
  output logic                                entry_done_o,
  output logic                                done_pulse_o,
  output logic                                err_pulse_o
);

  localparam int PW    = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(NUM_DIGITS + 1);
  localparam int MC_W  = $clog2(NUM_PRODUCTS + 1);
  localparam int IDX_W = $clog2(NUM_PRODUCTS);

  typedef enum logic {ST_ENTRY = 1'b0, ST_COMPLETE = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       barcode_q, barcode_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NUM_PRODUCTS-1:0] mask_q, mask_d;
  logic [MC_W-1:0]     mc_q, mc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                unique_q, unique_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [PW-1:0]           cand_code;
  logic [NUM_PRODUCTS-1:0] cand_mask;
  logic [PW-1:0]           bs_code;
  logic                    digit_legal;
`ifdef BARCODE_AUTOCOMPLETE_EN
  logic [PW-1:0]           full_code;
`endif

  // Product p matches when its top cnt digits equal the top cnt digits of code.
  function automatic logic [NUM_PRODUCTS-1:0] prefix_mask(input logic [PW-1:0] code,
                                                          input logic [CNT_W-1:0] cnt);
    logic [NUM_PRODUCTS-1:0] m;
    logic [PW-1:0] prod;
    m = {NUM_PRODUCTS{1'b1}};
    for (int p = 0; p < NUM_PRODUCTS; p++) begin
      prod = PRODUCT_TABLE[p*PW +: PW];
      for (int d = 0; d < NUM_DIGITS; d++) begin
        m[p] = m[p] & ((d >= int'(cnt)) ||
               (prod[(NUM_DIGITS-1-d)*DIGIT_W +: DIGIT_W] == code[(NUM_DIGITS-1-d)*DIGIT_W +: DIGIT_W]));
      end
    end
    return m;
  endfunction

  function automatic logic [MC_W-1:0] popcount(input logic [NUM_PRODUCTS-1:0] m);
    logic [MC_W-1:0] c;
    c = {MC_W{1'b0}};
    for (int p = 0; p < NUM_PRODUCTS; p++) c = c + MC_W'(m[p]);
    return c;
  endfunction

  // Scan from the top so the lowest set bit wins.
  function automatic logic [IDX_W-1:0] lowest_index(input logic [NUM_PRODUCTS-1:0] m);
    logic [IDX_W-1:0] ix;
    ix = {IDX_W{1'b0}};
    for (int p = NUM_PRODUCTS-1; p >= 0; p--) ix = m[p] ? IDX_W'(p) : ix;
    return ix;
  endfunction

  // Candidate entries for a digit append and for a backspace.
  always_comb begin
    digit_legal = (digit_in_i >= DIGIT_W'(1)) && (digit_in_i <= DIGIT_W'(DIGIT_MAX));
    cand_code   = barcode_q;
    bs_code     = barcode_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      cand_code[(NUM_DIGITS-1-d)*DIGIT_W +: DIGIT_W] = (d == int'(count_q)) ? digit_in_i
                                                      : barcode_q[(NUM_DIGITS-1-d)*DIGIT_W +: DIGIT_W];
      bs_code[(NUM_DIGITS-1-d)*DIGIT_W +: DIGIT_W]   = (d == int'(count_q) - 1) ? {DIGIT_W{1'b0}}
                                                      : barcode_q[(NUM_DIGITS-1-d)*DIGIT_W +: DIGIT_W];
    end
    cand_mask = prefix_mask(cand_code, count_q + CNT_W'(1));
`ifdef BARCODE_AUTOCOMPLETE_EN
    // Only used when exactly one bit of cand_mask is set, so OR-ing is a select.
    full_code = {PW{1'b0}};
    for (int p = 0; p < NUM_PRODUCTS; p++) begin
      full_code = full_code | (PRODUCT_TABLE[p*PW +: PW] & {PW{cand_mask[p]}});
    end
`endif
  end

  // Next-state: request arbitration, entry update and registered-output values.
  always_comb begin
    state_d   = state_q;
    barcode_d = barcode_q;
    count_d   = count_q;
    err_d     = 1'b0;
    done_d    = 1'b0;
    if (clear_i) begin
      state_d   = ST_ENTRY;
      barcode_d = {PW{1'b0}};
      count_d   = {CNT_W{1'b0}};
    end else if (backspace_i) begin
      if (count_q == {CNT_W{1'b0}}) begin
        err_d = 1'b1;
      end else begin
        state_d   = ST_ENTRY;
        barcode_d = bs_code;
        count_d   = count_q - CNT_W'(1);
      end
    end else if (digit_valid_i) begin
      case (state_q)
        ST_ENTRY: begin
          if (!digit_legal || (cand_mask == {NUM_PRODUCTS{1'b0}})) begin
            err_d = 1'b1;
          end else begin
            barcode_d = cand_code;
            count_d   = count_q + CNT_W'(1);
            if (count_d == CNT_W'(NUM_DIGITS)) begin
              state_d = ST_COMPLETE;
              done_d  = 1'b1;
`ifdef BARCODE_AUTOCOMPLETE_EN
            end else if (popcount(cand_mask) == MC_W'(1)) begin
              barcode_d = full_code;
              count_d   = CNT_W'(NUM_DIGITS);
              state_d   = ST_COMPLETE;
              done_d    = 1'b1;
`endif
            end else begin
              state_d = ST_ENTRY;
            end
          end
        end
        ST_COMPLETE: err_d = 1'b1;
        default: begin
          state_d   = ST_ENTRY;
          barcode_d = {PW{1'b0}};
          count_d   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
    mask_d   = prefix_mask(barcode_d, count_d);
    mc_d     = popcount(mask_d);
    idx_d    = lowest_index(mask_d);
    unique_d = (mc_d == MC_W'(1)) && (count_d != {CNT_W{1'b0}});
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ENTRY;
      barcode_q <= {PW{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      mask_q    <= {NUM_PRODUCTS{1'b1}};
      mc_q      <= MC_W'(NUM_PRODUCTS);
      idx_q     <= {IDX_W{1'b0}};
      unique_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      barcode_q <= barcode_d;
      count_q   <= count_d;
      mask_q    <= mask_d;
      mc_q      <= mc_d;
      idx_q     <= idx_d;
      unique_q  <= unique_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign barcode_o        = barcode_q;
  assign digit_count_o    = count_q;
  // Display gate applied to the registered mask, so blanking takes effect
  // without disturbing the match state or statistics.
  assign highlight_mask_o = mask_q & {NUM_PRODUCTS{highlight_en_i}};
  assign match_count_o    = mc_q;
  assign unique_match_o   = unique_q;
  assign match_index_o    = idx_q;
  assign entry_done_o     = (state_q == ST_COMPLETE);
  assign done_pulse_o     = done_q;
  assign err_pulse_o      = err_q;

endmodule

// File: tb/tb_barcode_prefix_matcher.sv
module tb_barcode_prefix_matcher;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        digit_valid_i;
  logic [3:0]  digit_in_i;
  logic        backspace_i;
  logic        clear_i;
  logic        highlight_en_i;
  logic [15:0] barcode_o;
  logic [2:0]  digit_count_o;
  logic [11:0] highlight_mask_o;
  logic [3:0]  match_count_o;
  logic        unique_match_o;
  logic [3:0]  match_index_o;
  logic        entry_done_o;
  logic        done_pulse_o;
  logic        err_pulse_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: digits entered so far and completion flag.
  int ent[$];
  bit complete;
  logic [191:0] table_v;

  barcode_prefix_matcher dut (
    .clk(clk), .rst_n(rst_n),
    .digit_valid_i(digit_valid_i), .digit_in_i(digit_in_i),
    .backspace_i(backspace_i), .clear_i(clear_i), .highlight_en_i(highlight_en_i),
    .barcode_o(barcode_o), .digit_count_o(digit_count_o),
    .highlight_mask_o(highlight_mask_o), .match_count_o(match_count_o),
    .unique_match_o(unique_match_o), .match_index_o(match_index_o),
    .entry_done_o(entry_done_o), .done_pulse_o(done_pulse_o), .err_pulse_o(err_pulse_o)
  );

  always #5 clk = ~clk;

  function automatic int product(input int i);
    return int'(table_v[i*16 +: 16]);
  endfunction

  // Prefix match by integer arithmetic: drop the unentered low digits of the product.
  function automatic logic [11:0] model_mask(input int dl[$]);
    logic [11:0] m;
    int pv;
    int n;
    n = dl.size();
    pv = 0;
    foreach (dl[k]) pv = pv * 16 + dl[k];
    m = 12'h000;
    for (int p = 0; p < 12; p++) begin
      if ((product(p) >> (4 * (4 - n))) == pv) m[p] = 1'b1;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input bit exp_err, input bit exp_done);
    logic [11:0] m;
    int mc;
    int ix;
    int bc;
    m = model_mask(ent);
    mc = $countones(m);
    ix = 0;
    for (int p = 11; p >= 0; p--) if (m[p]) ix = p;
    bc = 0;
    foreach (ent[k]) bc = bc + (ent[k] << (4 * (3 - k)));
    chk("barcode", 32'(barcode_o), 32'(bc));
    chk("count", 32'(digit_count_o), 32'(ent.size()));
    chk("mask", 32'(highlight_mask_o), 32'(highlight_en_i ? m : 12'h000));
    chk("match_count", 32'(match_count_o), 32'(mc));
    chk("unique", 32'(unique_match_o), 32'((mc == 1) && (ent.size() > 0)));
    chk("index", 32'(match_index_o), 32'(ix));
    chk("entry_done", 32'(entry_done_o), 32'(complete));
    chk("done_pulse", 32'(done_pulse_o), 32'(exp_done));
    chk("err_pulse", 32'(err_pulse_o), 32'(exp_err));
  endtask

  // Apply one cycle of requests, advance the model, compare everything.
  task automatic step(input bit clr, input bit bs, input bit dv, input int d);
    bit e;
    bit dn;
    int trial[$];
    logic [11:0] tm;
    clear_i = clr;
    backspace_i = bs;
    digit_valid_i = dv;
    digit_in_i = d[3:0];
    @(posedge clk);
    #1;
    e = 1'b0;
    dn = 1'b0;
    if (clr) begin
      ent = {};
      complete = 1'b0;
    end else if (bs) begin
      if (ent.size() == 0) e = 1'b1;
      else begin
        void'(ent.pop_back());
        complete = 1'b0;
      end
    end else if (dv) begin
      if (complete || d < 1 || d > 4) e = 1'b1;
      else begin
        trial = ent;
        trial.push_back(d);
        tm = model_mask(trial);
        if (tm == 12'h000) e = 1'b1;
        else begin
          ent = trial;
          if (ent.size() == 4) begin
            complete = 1'b1;
            dn = 1'b1;
          end
`ifdef BARCODE_AUTOCOMPLETE_EN
          else if ($countones(tm) == 1) begin
            for (int p = 0; p < 12; p++) begin
              if (tm[p]) begin
                ent = {};
                for (int k = 3; k >= 0; k--) ent.push_back((product(p) >> (4 * k)) & 15);
              end
            end
            complete = 1'b1;
            dn = 1'b1;
          end
`endif
        end
      end
    end
    check_all(e, dn);
    clear_i = 1'b0;
    backspace_i = 1'b0;
    digit_valid_i = 1'b0;
  endtask

  initial begin
    table_v = {16'h1213, 16'h1342, 16'h4321, 16'h3112, 16'h2144, 16'h2134, 16'h3214, 16'h3133,
               16'h3121, 16'h4133, 16'h4132, 16'h3124};
    rst_n = 1'b0;
    digit_valid_i = 1'b0;
    digit_in_i = 4'd0;
    backspace_i = 1'b0;
    clear_i = 1'b0;
    highlight_en_i = 1'b1;
    ent = {};
    complete = 1'b0;
    #12;
    // Reset state.
    check_all(1'b0, 1'b0);
    chk("rst_mask", 32'(highlight_mask_o), 32'h0FFF);
    chk("rst_mc", 32'(match_count_o), 32'd12);
    rst_n = 1'b1;
    highlight_en_i = 1'b0;
    step(0, 0, 0, 0);
    chk("gated_mask", 32'(highlight_mask_o), 32'h000);
    chk("gated_mc", 32'(match_count_o), 32'd12);
    highlight_en_i = 1'b1;

    // Full entry 3,1,2,4.
    step(0, 0, 1, 3);
    chk("d3_mask", 32'(highlight_mask_o), 32'h139);
    chk("d3_mc", 32'(match_count_o), 32'd5);
    chk("d3_bc", 32'(barcode_o), 32'h3000);
    step(0, 0, 1, 1);
    step(0, 0, 1, 2);
    chk("d312_mask", 32'(highlight_mask_o), 32'h009);
    step(0, 0, 1, 4);
    chk("full_bc", 32'(barcode_o), 32'h3124);
    chk("full_done", 32'(done_pulse_o), 32'd1);
    chk("full_uniq", 32'(unique_match_o), 32'd1);
    step(0, 0, 0, 0);
    chk("done_once", 32'(done_pulse_o), 32'd0);

    // Illegal and non-matching digits.
    step(1, 0, 0, 0);
    step(0, 0, 1, 1);
    chk("d1_mask", 32'(highlight_mask_o), 32'hC00);
    step(0, 0, 1, 1);
    chk("d11_err", 32'(err_pulse_o), 32'd1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 5);
    chk("d5_count", 32'(digit_count_o), 32'd1);

    // COMPLETE behaviour, backspace and priority.
    step(1, 0, 0, 0);
    step(0, 0, 1, 3);
    step(0, 0, 1, 1);
    step(0, 0, 1, 2);
    step(0, 0, 1, 4);
    step(0, 0, 1, 2);
    step(0, 1, 0, 0);
    chk("bs_bc", 32'(barcode_o), 32'h3120);
    chk("bs_mask", 32'(highlight_mask_o), 32'h009);
    step(1, 1, 1, 2);
    step(0, 1, 0, 0);
    chk("bs0_err", 32'(err_pulse_o), 32'd1);

    // Asynchronous reset mid-entry.
    step(0, 0, 1, 4);
    step(0, 0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    ent = {};
    complete = 1'b0;
    check_all(1'b0, 1'b0);
    #2;
    rst_n = 1'b1;

    // 2,1,4: autocomplete-dependent.
    step(0, 0, 1, 2);
    step(0, 0, 1, 1);
    step(0, 0, 1, 4);
`ifdef BARCODE_AUTOCOMPLETE_EN
    chk("ac_bc", 32'(barcode_o), 32'h2144);
    chk("ac_count", 32'(digit_count_o), 32'd4);
    chk("ac_index", 32'(match_index_o), 32'd7);
`else
    chk("na_bc", 32'(barcode_o), 32'h2140);
    chk("na_count", 32'(digit_count_o), 32'd3);
    chk("na_done", 32'(entry_done_o), 32'd0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      highlight_en_i = ($urandom_range(0, 9) != 0);
      step($urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) < 7, int'($urandom_range(0, 5)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
